speck32_decrypt_core: RTL and testbench
=======================================

# speck32_decrypt_core

Iterative SPECK32/64 decryption engine: the receive-side counterpart to the team's SPECK32/64 encryption datapath built from majority-gate logic. It expands a 64-bit key into 22 round keys held in a local register file, then runs the inverse round once per clock, from round key 21 down to round key 0. It sits behind the key/ciphertext capture logic and delivers 32-bit plaintext blocks with a one-cycle done strobe.

## Interface
Parameters:
- ROUNDS, 22, round count; fixed for SPECK32/64, no other value supported
- WORD, 16, word width; fixed

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset, synchronous and active-high
- key_in  input  64  key {l2, l1, l0, k0}; k0 = key_in[15:0], l2 = key_in[63:48]
- key_load  input  1  pulse; accepted only in IDLE
- ct_in  input  32  ciphertext {x, y}; x = ct_in[31:16]
- start  input  1  pulse; accepted only in IDLE with key_ready = 1
- pt_out  output  32  plaintext {x, y}; held until the next accepted start
- done  output  1  one-cycle strobe; pt_out is valid in the same cycle
- busy  output  1  high in EXPAND and DECRYPT
- key_ready  output  1  round-key file is valid

## Operation
- FSM states: IDLE, EXPAND, DECRYPT. All arithmetic is mod 2^16. ROR and ROL are rotates within 16 bits.
- IDLE with key_load: capture k[0] = k0 and the window (a, b, c) = (l0, l1, l2). Set i = 0, clear key_ready, go to EXPAND.
- EXPAND, one edge per step:
  - compute l' = (k[i] + ROR(a,7)) ^ i
  - write k[i+1] = ROL(k[i],2) ^ l'
  - shift the window to (b, c, l'), then i++
  - the edge that writes k[21] sets key_ready and returns to IDLE; expansion takes 21 edges.
- IDLE with start and key_ready: load x, y from ct_in, set r = 21, go to DECRYPT.
- DECRYPT, one edge per round:
  - y' = ROR(x ^ y, 2)
  - x' = ROL((x ^ k[r]) - y', 7)
  - r--
  - the edge that applies k[0] writes pt_out = {x', y'}, pulses done, and returns to IDLE.
- key_load and start are ignored while busy. No queuing.
- key_load and start together in IDLE: key_load wins and start is dropped.
- start with key_ready = 0: ignored, no done.
- rst asserted at any time, including mid-expansion or mid-round: state goes to IDLE, and pt_out = 0, done = 0, busy = 0, key_ready = 0. The round-key file need not be cleared because key_ready gates its use.
- A key, once expanded, stays valid for any number of blocks until the next key_load or rst.

## Timing
- Reset values: pt_out = 32'h0, done = 0, busy = 0, key_ready = 0.
- Key expansion: key_ready rises 21 cycles after the key_load edge. busy is high for those 21 cycles.
- Decryption latency: done rises 22 cycles after the accepted start edge. busy is high for those 22 cycles.
- A new start is accepted on the cycle where done = 1, because the FSM is already in IDLE. Back-to-back throughput is one block per 23 cycles.
- One round key is read per cycle. The k[r] read is combinational from the register file.

## Configuration
- SPECK_DEC_MMIG_XOR_EN
  - Defined: every 16-bit XOR (x ^ y, x ^ k[r], and the key-schedule XORs) is instantiated from the team's 16-bit majority-gate XOR cell.
  - Undefined: the XORs use the behavioral ^ operator.
- Cycle timing and results are identical in both builds.

## Test plan
- Standard vector: rst, key_load with key_in = 64'h1918_1110_0908_0100, wait for key_ready, start with ct_in = 32'ha868_42f2. Required: done exactly 22 cycles after start, pt_out = 32'h6574_694c.
- Key timing: after key_load, key_ready = 0 for 20 cycles and rises on cycle 21. busy is high throughout. k[21] = 16'h1be4 (standard schedule last round key).
- Ignored requests:
  - start before any key_load: no done, busy stays 0.
  - key_load or start pulsed mid-DECRYPT: result unchanged at 32'h6574_694c, no extra done.
- Back-to-back: start re-asserted on the done cycle with the same ct_in. Required: a second done 22 cycles later, same pt_out.
- Reset mid-operation: rst at round 10. Required: next cycle busy = 0, key_ready = 0, pt_out = 0. A subsequent start without key_load is ignored.
- Build equivalence: run the standard vector plus 1000 random key/ct pairs against a software reference model, with and without SPECK_DEC_MMIG_XOR_EN. Required: zero mismatches and identical done cycles.

Source files
------------

// File: rtl/speck32_decrypt_core.sv
// Iterative SPECK32/64 decryption: 21-step key expansion into a local round-key file, then one inverse round per clock.
// Build option SPECK_DEC_MMIG_XOR_EN swaps every 16-bit XOR for the majority-gate XOR cell.

`ifdef SPECK_DEC_MMIG_XOR_EN
// 16-bit XOR from three majority gates per bit: M(M(a,~b,0), M(~a,b,0), 1).
module speck_mmig_xor16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic [15:0] t1;
    logic [15:0] t2;

    for (genvar gi = 0; gi < 16; gi++) begin : g_bit
        assign t1[gi] = (a[gi] & ~b[gi]) | (a[gi] & 1'b0) | (~b[gi] & 1'b0);
        assign t2[gi] = (~a[gi] & b[gi]) | (~a[gi] & 1'b0) | (b[gi] & 1'b0);
        assign y[gi]  = (t1[gi] & t2[gi]) | (t1[gi] & 1'b1) | (t2[gi] & 1'b1);
    end
endmodule
`endif

module speck32_decrypt_core #(
    parameter int ROUNDS = 22,
    parameter int WORD   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        key_load,
    input  logic [31:0] ct_in,
    input  logic        start,
    output logic [31:0] pt_out,
    output logic        done,
    output logic        busy,
    output logic        key_ready
);
    typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT} state_t;

    state_t            state_reg, state_next;
    logic [WORD-1:0]   a_reg, a_next, b_reg, b_next, c_reg, c_next;
    logic [4:0]        idx_reg, idx_next;
    logic [4:0]        rnd_reg, rnd_next;
    logic [WORD-1:0]   x_reg, x_next, y_reg, y_next;
    logic [31:0]       pt_reg, pt_next;
    logic              done_reg, done_next;
    logic              key_ready_reg, key_ready_next;

    logic [WORD-1:0]   rk_mem [0:ROUNDS-1];
    logic              rk_we;
    logic [4:0]        rk_waddr;
    logic [WORD-1:0]   rk_wdata;

    // One read port serves both phases: k[i] while expanding, k[r] while decrypting.
    logic [4:0]        rd_addr;
    logic [WORD-1:0]   k_rd;
    logic [WORD-1:0]   ks_sum, ks_idx, l_new, k_rot, k_new;
    logic [WORD-1:0]   xy, y_new, xk, x_new;

    assign rd_addr = (state_reg == EXPAND) ? idx_reg : rnd_reg;
    assign k_rd    = rk_mem[rd_addr];

    assign ks_sum  = k_rd + {a_reg[6:0], a_reg[15:7]};
    assign ks_idx  = {11'd0, idx_reg};
    assign k_rot   = {k_rd[13:0], k_rd[15:14]};
    assign y_new   = {xy[1:0], xy[15:2]};
    assign x_new   = {(xk - y_new) >> 9 | (xk - y_new) << 7};

`ifdef SPECK_DEC_MMIG_XOR_EN
    speck_mmig_xor16 u_xor_l  (.a(ks_sum), .b(ks_idx), .y(l_new));
    speck_mmig_xor16 u_xor_k  (.a(k_rot),  .b(l_new),  .y(k_new));
    speck_mmig_xor16 u_xor_xy (.a(x_reg),  .b(y_reg),  .y(xy));
    speck_mmig_xor16 u_xor_xk (.a(x_reg),  .b(k_rd),   .y(xk));
`else
    assign l_new = ks_sum ^ ks_idx;
    assign k_new = k_rot ^ l_new;
    assign xy    = x_reg ^ y_reg;
    assign xk    = x_reg ^ k_rd;
`endif

    always_comb begin
        state_next     = state_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        c_next         = c_reg;
        idx_next       = idx_reg;
        rnd_next       = rnd_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        pt_next        = pt_reg;
        done_next      = 1'b0;
        key_ready_next = key_ready_reg;
        rk_we          = 1'b0;
        rk_waddr       = '0;
        rk_wdata       = '0;
        case (state_reg)
            IDLE: begin
                // key_load has priority over start when both arrive together.
                if (key_load) begin
                    rk_we          = 1'b1;
                    rk_waddr       = '0;
                    rk_wdata       = key_in[15:0];
                    a_next         = key_in[31:16];
                    b_next         = key_in[47:32];
                    c_next         = key_in[63:48];
                    idx_next       = '0;
                    key_ready_next = 1'b0;
                    state_next     = EXPAND;
                end else if (start && key_ready_reg) begin
                    x_next     = ct_in[31:16];
                    y_next     = ct_in[15:0];
                    rnd_next   = 5'(ROUNDS - 1);
                    state_next = DECRYPT;
                end
            end
            EXPAND: begin
                rk_we    = 1'b1;
                rk_waddr = idx_reg + 5'd1;
                rk_wdata = k_new;
                a_next   = b_reg;
                b_next   = c_reg;
                c_next   = l_new;
                idx_next = idx_reg + 5'd1;
                if (idx_reg == 5'(ROUNDS - 2)) begin
                    key_ready_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            DECRYPT: begin
                x_next   = x_new;
                y_next   = y_new;
                rnd_next = rnd_reg - 5'd1;
                if (rnd_reg == 5'd0) begin
                    pt_next    = {x_new, y_new};
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            c_reg         <= '0;
            idx_reg       <= '0;
            rnd_reg       <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            pt_reg        <= '0;
            done_reg      <= 1'b0;
            key_ready_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            c_reg         <= c_next;
            idx_reg       <= idx_next;
            rnd_reg       <= rnd_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            pt_reg        <= pt_next;
            done_reg      <= done_next;
            key_ready_reg <= key_ready_next;
        end
    end

    // Round-key file is not cleared on reset; key_ready gates every use of it.
    always_ff @(posedge clk) begin
        if (!rst && rk_we) begin
            rk_mem[rk_waddr] <= rk_wdata;
        end
    end

    assign pt_out    = pt_reg;
    assign done      = done_reg;
    assign busy      = (state_reg != IDLE);
    assign key_ready = key_ready_reg;
endmodule

// File: tb/tb_speck32_decrypt_core.sv
// Self-checking bench for speck32_decrypt_core: directed scenarios plus random key/ciphertext blocks vs a software SPECK32/64 model.
module tb_speck32_decrypt_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key_in;
    logic        key_load;
    logic [31:0] ct_in;
    logic        start;
    logic [31:0] pt_out;
    logic        done;
    logic        busy;
    logic        key_ready;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] STD_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] STD_CT  = 32'ha868_42f2;
    localparam logic [31:0] STD_PT  = 32'h6574_694c;

    speck32_decrypt_core dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_load  (key_load),
        .ct_in     (ct_in),
        .start     (start),
        .pt_out    (pt_out),
        .done      (done),
        .busy      (busy),
        .key_ready (key_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ror16(input logic [15:0] v, input int n);
        return (v >> n) | (v << (16 - n));
    endfunction

    function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    // Reference: full key schedule followed by 22 inverse rounds.
    function automatic logic [31:0] ref_decrypt(input logic [63:0] key, input logic [31:0] ct);
        logic [15:0] k [22];
        logic [15:0] l [24];
        logic [15:0] x, y;
        k[0] = key[15:0];
        l[0] = key[31:16];
        l[1] = key[47:32];
        l[2] = key[63:48];
        for (int i = 0; i < 21; i++) begin
            l[i+3] = (k[i] + ror16(l[i], 7)) ^ 16'(i);
            k[i+1] = rol16(k[i], 2) ^ l[i+3];
        end
        x = ct[31:16];
        y = ct[15:0];
        for (int r = 21; r >= 0; r--) begin
            y = ror16(x ^ y, 2);
            x = rol16((x ^ k[r]) - y, 7);
        end
        return {x, y};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [63:0] key, input bit check_timing);
        key_in   = key;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        for (int n = 0; n <= 21; n++) begin
            if (n > 0) step();
            if (check_timing) begin
                n_checks++;
                if (key_ready !== (n == 21) || busy !== (n != 21)) begin
                    n_fail++;
                    $display("FAIL key_timing cycle %0d: key_ready=%b busy=%b, required key_ready=%b busy=%b",
                             n, key_ready, busy, (n == 21), (n != 21));
                end
            end
        end
        if (!check_timing) begin
            n_checks++;
            if (key_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL key_ready_after_load: got %b, required 1", key_ready);
            end
        end
    endtask

    // Starts one block and waits (bounded) for done; inject_at > 0 pulses key_load+start at that cycle.
    task automatic run_block(input logic [31:0] ct, input int inject_at,
                             output int cyc, output logic [31:0] pt);
        ct_in = ct;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == inject_at) begin
                key_in   = {$urandom, $urandom};
                key_load = 1'b1;
                start    = 1'b1;
            end
            step();
            key_load = 1'b0;
            start    = 1'b0;
            if (done === 1'b1) begin
                cyc = n;
                break;
            end
        end
        pt = pt_out;
    endtask

    task automatic check_block(input string name, input int cyc, input logic [31:0] pt,
                               input logic [31:0] exp_pt);
        n_checks++;
        if (cyc !== 22) begin
            n_fail++;
            $display("FAIL %s latency: done after %0d cycles, required 22", name, cyc);
        end
        n_checks++;
        if (pt !== exp_pt) begin
            n_fail++;
            $display("FAIL %s pt_out: got %h, required %h", name, pt, exp_pt);
        end
    endtask

    task automatic expect_idle_quiet(input string name, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            step();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s cycle %0d: done=%b busy=%b, required 0/0", name, n, done, busy);
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({pt_out, done, busy, key_ready} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_values: pt_out=%h done=%b busy=%b key_ready=%b, required all 0",
                     pt_out, done, busy, key_ready);
        end
        rst = 1'b0;
        step();
        $display("reset: pt_out=%h done=%b busy=%b key_ready=%b", pt_out, done, busy, key_ready);
    endtask

    task automatic test_start_without_key();
        ct_in = STD_CT;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nokey_start_busy: got %b, required 0", busy);
        end
        expect_idle_quiet("nokey_start", 30);
        $display("start without key: ignored");
    endtask

    task automatic test_standard_vector();
        int cyc;
        logic [31:0] pt;
        load_key(STD_KEY, 1'b1);
        run_block(STD_CT, 0, cyc, pt);
        check_block("standard", cyc, pt, STD_PT);
        $display("standard: key=%h ct=%h pt=%h cyc=%0d", STD_KEY, STD_CT, pt, cyc);
        step();
        n_checks++;
        if (done !== 1'b0 || pt_out !== STD_PT) begin
            n_fail++;
            $display("FAIL done_strobe_width: done=%b pt_out=%h, required 0 and %h", done, pt_out, STD_PT);
        end
    endtask

    task automatic test_ignored_mid_decrypt();
        int cyc;
        logic [31:0] pt;
        run_block(STD_CT, 9, cyc, pt);
        check_block("mid_decrypt_requests", cyc, pt, STD_PT);
        $display("mid-decrypt key_load+start: pt=%h cyc=%0d", pt, cyc);
        n_checks++;
        if (key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_decrypt_key_ready: got %b, required 1", key_ready);
        end
        expect_idle_quiet("no_extra_done", 30);
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [31:0] pt;
        run_block(STD_CT, 0, cyc, pt);
        check_block("b2b_first", cyc, pt, STD_PT);
        run_block(STD_CT, 0, cyc, pt);
        check_block("b2b_second", cyc, pt, STD_PT);
        $display("back-to-back: second pt=%h cyc=%0d", pt, cyc);
    endtask

    task automatic test_random(input int blocks);
        logic [63:0] key;
        logic [31:0] ct, pt, exp_pt;
        int cyc;
        key = '0;
        for (int b = 0; b < blocks; b++) begin
            if (b % 4 == 0) begin
                key = {$urandom, $urandom};
                load_key(key, 1'b0);
            end
            ct = $urandom;
            exp_pt = ref_decrypt(key, ct);
            run_block(ct, 0, cyc, pt);
            check_block("random", cyc, pt, exp_pt);
            $display("blk %0d key=%h ct=%h pt=%h exp=%h cyc=%0d", b, key, ct, pt, exp_pt, cyc);
        end
    endtask

    task automatic test_reset_mid();
        ct_in = STD_CT;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 10; n++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || key_ready !== 1'b0 || pt_out !== 32'h0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b key_ready=%b pt_out=%h done=%b, required 0/0/0/0",
                     busy, key_ready, pt_out, done);
        end
        ct_in = STD_CT;
        start = 1'b1;
        step();
        start = 1'b0;
        expect_idle_quiet("after_reset_start", 30);
        $display("reset mid-decrypt: state cleared, later start ignored");
    endtask

    initial begin
        rst      = 1'b1;
        key_in   = '0;
        key_load = 1'b0;
        ct_in    = '0;
        start    = 1'b0;
        step();
        step();
        test_reset();
        test_start_without_key();
        test_standard_vector();
        test_ignored_mid_decrypt();
        test_back_to_back();
        test_random(1000);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
